// File: rtl/uart_fifo_pkg.sv
// Shared defaults, operation encoding and width helper for the UART FIFO.
// No logic, no latency, no backpressure; compile-time constants only.
package uart_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 32;

    // Per-cycle action after enable, flush and acceptance are resolved.
    typedef enum logic [2:0] {
        OP_IDLE,
        OP_WRITE,
        OP_READ,
        OP_BOTH,
        OP_FLUSH
    } op_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_fifo_if.sv
// Request/response bundle between a UART FIFO client (master) and the FIFO (slave).
// Pure wiring: no latency; the client watches FULL/EMPTY/Count to pace itself.
interface uart_fifo_if
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = clog2(DEPTH) + 1;

    logic             en;
    logic             flush;
    logic             wr;
    logic [WIDTH-1:0] data_in;
    logic             rd;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             empty;
    logic             full;
    logic             aempty;
    logic             afull;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;

    modport master (
        output en, flush, wr, data_in, rd, clr_err,
        input  data_out, valid, empty, full, aempty, afull, count, ovf, udf
    );

    modport slave (
        input  en, flush, wr, data_in, rd, clr_err,
        output data_out, valid, empty, full, aempty, afull, count, ovf, udf
    );

endinterface

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH dual-port storage with synchronous write and registered read; nothing is reset.
// Read data appears one edge after rd_en and holds otherwise; no backpressure.
module fifo_mem
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]       wr_dat,
    input  logic                   rd_en,
    input  logic [clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]       rd_dat
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_dat_d;
    logic [WIDTH-1:0] rd_dat_q;

    // Same-address read and write returns the old word, which keeps order when full.
    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            rd_dat_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/uart_fifo.sv
// Synchronous FIFO control for a UART datapath: pointers, occupancy, flags and sticky errors.
// Read data one edge after an accepted RD (no fall-through); writes refused when full unless a read frees a slot.
module uart_fifo
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input logic       clk,
    input logic       rst_n,
    uart_fifo_if.slave bus
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_d, wr_ptr_q;
    logic [AW-1:0]    rd_ptr_d, rd_ptr_q;
    logic [CW-1:0]    count_d, count_q;
    logic             valid_d, valid_q;
    logic             seen_d, seen_q;
    logic             ovf_d, ovf_q;
    logic             udf_d, udf_q;
    logic             empty, full;
    logic             rd_acc, wr_acc;
    logic             ovf_set, udf_set;
    logic [WIDTH-1:0] rd_dat;
    op_e              op;

    assign empty = (count_q == '0);
    assign full  = (int'(count_q) == DEPTH);

    // Flush outranks RD/WR, so it also suppresses acceptance and error detection.
    always_comb begin
        rd_acc  = bus.en && !bus.flush && bus.rd && !empty;
        wr_acc  = bus.en && !bus.flush && bus.wr && (!full || rd_acc);
        ovf_set = bus.en && !bus.flush && bus.wr && !wr_acc;
        udf_set = bus.en && !bus.flush && bus.rd && empty;
        op      = OP_IDLE;
        if (bus.en && bus.flush) begin
            op = OP_FLUSH;
        end else if (rd_acc && wr_acc) begin
            op = OP_BOTH;
        end else if (wr_acc) begin
            op = OP_WRITE;
        end else if (rd_acc) begin
            op = OP_READ;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = rd_acc;
        seen_d   = seen_q | rd_acc;
        unique case (op)
            OP_FLUSH: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end
            OP_WRITE: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + CW'(1);
            end
            OP_READ: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - CW'(1);
            end
            OP_BOTH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            default: begin
            end
        endcase
        ovf_d = ovf_set | (ovf_q & ~bus.clr_err);
        udf_d = udf_set | (udf_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            seen_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_dat  (bus.data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q),
        .rd_dat  (rd_dat)
    );

    // The storage read register has no reset; mask it until the first pop since reset.
    assign bus.data_out = seen_q ? rd_dat : '0;
    assign bus.valid    = valid_q;
    assign bus.count    = count_q;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.aempty   = (int'(count_q) <= AEMPTY_TH);
    assign bus.afull    = (int'(count_q) >= AFULL_TH);
    assign bus.ovf      = ovf_q;
    assign bus.udf      = udf_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Randomised and directed checks of uart_fifo against a queue-based reference model.
module tb_uart_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 32;

    logic clk;
    logic rst_n;
    int   check_cnt;
    int   fail_cnt;

    uart_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    uart_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_valid;
    logic             m_ovf;
    logic             m_udf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        int n;
        n = mq.size();
        check("count",    32'(bus.count),    32'(n));
        check("data_out", 32'(bus.data_out), 32'(m_dout));
        check("valid",    32'(bus.valid),    32'(m_valid));
        check("empty",    32'(bus.empty),    32'(n == 0));
        check("full",     32'(bus.full),     32'(n == DEPTH));
        check("afull",    32'(bus.afull),    32'(n >= DEPTH - 4));
        check("aempty",   32'(bus.aempty),   32'(n <= 4));
        check("ovf",      32'(bus.ovf),      32'(m_ovf));
        check("udf",      32'(bus.udf),      32'(m_udf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic drive_idle();
        bus.en      = 1'b0;
        bus.flush   = 1'b0;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.clr_err = 1'b0;
        bus.data_in = '0;
    endtask

    // One clock of stimulus: drive at negedge, predict, check just after the posedge.
    task automatic step(input logic en, input logic wr, input logic rd,
                        input logic flush, input logic clr, input logic [WIDTH-1:0] din);
        bit rd_ok, wr_ok, o_set, u_set;
        @(negedge clk);
        bus.en      = en;
        bus.wr      = wr;
        bus.rd      = rd;
        bus.flush   = flush;
        bus.clr_err = clr;
        bus.data_in = din;
        rd_ok   = 0;
        wr_ok   = 0;
        o_set   = 0;
        u_set   = 0;
        m_valid = 1'b0;
        if (en && flush) begin
            mq.delete();
        end else if (en) begin
            rd_ok = rd && (mq.size() != 0);
            wr_ok = wr && ((mq.size() < DEPTH) || rd_ok);
            o_set = wr && !wr_ok;
            u_set = rd && (mq.size() == 0);
            if (rd_ok) begin
                m_dout  = mq.pop_front();
                m_valid = 1'b1;
            end
            if (wr_ok) mq.push_back(din);
        end
        m_ovf = o_set || (m_ovf && !clr);
        m_udf = u_set || (m_udf && !clr);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        check_cnt = 0;
        fail_cnt  = 0;
        drive_idle();
        model_reset();
        rst_n = 1'b0;
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 0x01..0x20, then one write too many.
        for (int i = 1; i <= DEPTH; i++) step(1, 1, 0, 0, 0, 8'(i));
        step(1, 1, 0, 0, 0, 8'h21);
        step(1, 0, 0, 0, 1, 8'h00);

        // Drain in order, then one read too many.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 0, 0, 8'h00);
        step(1, 0, 1, 0, 0, 8'h00);
        step(1, 0, 0, 0, 1, 8'h00);

        // Simultaneous read and write while full, then while empty.
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, 0, 8'($urandom));
        step(1, 1, 1, 0, 0, 8'hAA);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 0, 0, 8'h00);
        step(1, 1, 1, 0, 0, 8'h55);
        step(1, 0, 1, 0, 1, 8'h00);

        // Steady streaming at low occupancy across several pointer wraps.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 8'($urandom));
        for (int i = 0; i < 100; i++) step(1, 1, 1, 0, 0, 8'($urandom));
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 8'h00);

        // Flush at ten entries with a concurrent read.
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 8'($urandom));
        step(1, 0, 1, 1, 0, 8'h00);

        // Arm both error flags, then freeze with EN=0 while clearing them.
        step(1, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, 0, 8'($urandom));
        step(1, 1, 0, 0, 0, 8'h77);
        step(1, 0, 1, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 20; i++)
            step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'(i == 10), 8'($urandom));

        // Random traffic, first write-biased then read-biased.
        for (int i = 0; i < 600; i++) begin
            logic wr_b, rd_b;
            wr_b = (i < 300) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            rd_b = (i < 300) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            step(1'($urandom_range(0, 9) != 0), wr_b, rd_b,
                 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 19) == 0), 8'($urandom));
        end

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 6; i++) step(1, 1, i[0], 0, 0, 8'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 0, 0, 8'h3C);
        step(1, 0, 1, 0, 0, 8'h00);
        step(1, 0, 1, 0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of entries; SHALL be a power of two, at least 4.
REQ-003 Parameter AFULL_TH, default DEPTH-4, AFULL asserts when Count >= AFULL_TH.
REQ-004 Parameter AEMPTY_TH, default 4, AEMPTY asserts when Count <= AEMPTY_TH.
REQ-005 Clk  in  1  single clock; all state updates on its rising edge.
REQ-006 Rst_n  in  1  asynchronous, active-low reset.
REQ-007 EN  in  1  global enable; when 0, RD/WR/FLUSH are ignored.
REQ-008 FLUSH  in  1  synchronous empty request.
REQ-009 WR  in  1  write request.
REQ-010 dataIn  in  WIDTH  write data.
REQ-011 RD  in  1  read request.
REQ-012 dataOut  out  WIDTH  registered read data.
REQ-013 VALID  out  1  one-cycle pulse; dataOut carries a newly popped word.
REQ-014 EMPTY / FULL  out  1 each  Count==0 / Count==DEPTH.
REQ-015 AEMPTY / AFULL  out  1 each  threshold flags per REQ-003/004.
REQ-016 Count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH inclusive.
REQ-017 OVF / UDF  out  1 each  sticky overflow / underflow error flags.
REQ-018 CLR_ERR  in  1  synchronous clear of OVF and UDF.

Function
REQ-019 A read is accepted when EN && RD && !EMPTY; a write is accepted when EN && WR && (!FULL || read accepted).
REQ-020 Accepted read: dataOut SHALL present the oldest word at the next edge, with VALID=1 for exactly that cycle; otherwise dataOut holds and VALID=0.
REQ-021 No fall-through: with EMPTY=1, simultaneous RD and WR SHALL accept only the write; Count becomes 1, VALID stays 0, and UDF sets.
REQ-022 With FULL=1, simultaneous RD and WR SHALL accept both; Count stays DEPTH and order is preserved.
REQ-023 Count SHALL update in the same edge as acceptance: +1 for write only, -1 for read only, unchanged for both or neither.
REQ-024 Read and write pointers are clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 with no gap; occupancy comes from Count, never from pointer comparison.
REQ-025 All flags SHALL be combinational decodes of Count and SHALL be valid regardless of EN.
REQ-026 FLUSH (EN=1) SHALL zero both pointers and Count and take priority over RD and WR in the same cycle; memory contents, dataOut and error flags are retained, and VALID=0.
REQ-027 OVF SHALL set on EN && WR with the write not accepted; UDF SHALL set on EN && RD && EMPTY. Neither sets while FLUSH is active.
REQ-028 CLR_ERR SHALL clear OVF and UDF; a same-cycle set condition wins over the clear.
REQ-029 With EN=0, no pointer, Count, memory, dataOut, VALID or error state SHALL change, except that CLR_ERR still acts.

Reset
REQ-030 Rst_n=0 SHALL immediately force the pointers, Count, dataOut, VALID, OVF and UDF to 0, which gives EMPTY=1, AEMPTY=1, FULL=0 and AFULL=0.
REQ-031 Memory array contents SHALL NOT be reset.
REQ-032 Reset deassertion is synchronised externally; the first request SHALL be honoured on the first rising edge with Rst_n=1.

Structure
REQ-033 A shared package SHALL hold the default WIDTH/DEPTH constants and a clog2 function used for pointer and Count widths.
REQ-034 Storage SHALL be one sub-module, fifo_mem: a WIDTH x DEPTH dual-port array with synchronous write and registered read, with no reset; uart_fifo holds the control logic.
REQ-035 The top level SHALL elaborate for WIDTH in 1..32 and DEPTH in 4..1024 with no other changes.

Verification
REQ-036 Reset, then write 0x01..0x20 (32 words, default parameters) -> FULL=1, Count=32, AFULL asserted from Count=28; a 33rd write sets OVF with Count unchanged.
REQ-037 Read 32 words -> dataOut sequence 0x01..0x20, each word one cycle after its RD with VALID pulsing; after the last, EMPTY=1; an extra RD sets UDF with VALID=0.
REQ-038 Simultaneous RD and WR while full -> Count stays 32 and the 0xAA written returns in order after the 31 older words; the same while empty -> Count=1, VALID=0, UDF=1.
REQ-039 Loop 100 words at Count around 3 across the pointer wrap -> no loss or reorder; AEMPTY stays 1 throughout.
REQ-040 FLUSH at Count=10 with RD=1 -> Count=0 and VALID=0 next cycle; Rst_n pulsed low mid-burst -> all outputs immediately at reset values.
REQ-041 EN=0 with WR, RD and FLUSH toggling -> Count, dataOut and flags frozen; CLR_ERR in the same window -> OVF and UDF cleared.
